// File: rtl/pingpong_pkg.sv
// Shared definitions for the score BCD scheduler: FSM state encoding and datapath widths.
// Pure declarations; no logic, latency or flow control of its own.
package pingpong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WRITE  = 2'd2
   } state_t;

   localparam int BIN_W = 8;
   localparam int BCD_W = 12;
   localparam int CNT_W = 4;

endpackage

// File: rtl/score_bcd_scheduler_bin2bcd.sv
// Combinational 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// Zero latency, no flow control; the scheduler decides when its output is valid.
module BinaryToBCD
   import pingpong_pkg::*;
(
   input  logic [BIN_W-1:0] bin,
   output logic [BCD_W-1:0] bcd
);

   logic [BIN_W+BCD_W-1:0] sh;

   always_comb begin
      sh = {{BCD_W{1'b0}}, bin};
      for (int i = 0; i < BIN_W; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (sh[BIN_W+4*d +: 4] >= 4'd5) begin
               sh[BIN_W+4*d +: 4] = sh[BIN_W+4*d +: 4] + 4'd3;
            end
         end
         sh = sh << 1;
      end
      bcd = sh[BIN_W +: BCD_W];
   end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Round-robin time-sharing of one binary-to-BCD converter between players A and B.
// Latency: ack SETTLE_CYCLES+1 edges after the request is sampled; requests arriving while busy are held off until IDLE.
module score_bcd_scheduler
   import pingpong_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_SCORE     = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [7:0]       score_a,
   input  logic [7:0]       score_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic [11:0]      bcd_a,
   output logic [11:0]      bcd_b,
   output logic             sat_a,
   output logic             sat_b,
   output logic             busy
);

   localparam logic [BIN_W-1:0] MAX_L    = BIN_W'(MAX_SCORE);
   localparam logic [BIN_W:0]   MAX_W    = (BIN_W + 1)'(MAX_SCORE);
   localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE_CYCLES);

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               owner_q, owner_d;     // 0 = A, 1 = B
   logic               last_b_q, last_b_d;   // B was granted most recently
   logic               pend_sat_q, pend_sat_d;
   logic [BCD_W-1:0]   bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
   logic               sat_a_q, sat_a_d, sat_b_q, sat_b_d;
   logic               ack_a_q, ack_a_d, ack_b_q, ack_b_d;

   logic               grant_b;
   logic               op_over;
   logic [BIN_W-1:0]   op;
   logic [BCD_W-1:0]   conv_bcd;

   BinaryToBCD u_conv (
      .bin (bin_q),
      .bcd (conv_bcd)
   );

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      last_b_d   = last_b_q;
      pend_sat_d = pend_sat_q;
      bcd_a_d    = bcd_a_q;
      bcd_b_d    = bcd_b_q;
      sat_a_d    = sat_a_q;
      sat_b_d    = sat_b_q;
      ack_a_d    = 1'b0;
      ack_b_d    = 1'b0;

      grant_b = req_b && (!req_a || !last_b_q);
      op      = grant_b ? score_b : score_a;
      op_over = {1'b0, op} > MAX_W;

      case (state_q)
         ST_IDLE: begin
            if (req_a || req_b) begin
               owner_d    = grant_b;
               last_b_d   = grant_b;
               pend_sat_d = op_over;
               bin_d      = op_over ? MAX_L : op;
               cnt_d      = SETTLE_L;
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd1) begin
               cnt_d   = '0;
               state_d = ST_WRITE;
               if (owner_q) begin
                  bcd_b_d = conv_bcd;
                  sat_b_d = pend_sat_q;
                  ack_b_d = 1'b1;
               end else begin
                  bcd_a_d = conv_bcd;
                  sat_a_d = pend_sat_q;
                  ack_a_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Ack flops are loaded on entry to WRITE so they track that state exactly.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         cnt_q      <= '0;
         owner_q    <= 1'b0;
         last_b_q   <= 1'b1;
         pend_sat_q <= 1'b0;
         bcd_a_q    <= '0;
         bcd_b_q    <= '0;
         sat_a_q    <= 1'b0;
         sat_b_q    <= 1'b0;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         last_b_q   <= last_b_d;
         pend_sat_q <= pend_sat_d;
         bcd_a_q    <= bcd_a_d;
         bcd_b_q    <= bcd_b_d;
         sat_a_q    <= sat_a_d;
         sat_b_q    <= sat_b_d;
         ack_a_q    <= ack_a_d;
         ack_b_q    <= ack_b_d;
      end
   end

   assign ack_a = ack_a_q;
   assign ack_b = ack_b_q;
   assign bcd_a = bcd_a_q;
   assign bcd_b = bcd_b_q;
   assign sat_a = sat_a_q;
   assign sat_b = sat_b_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench: three scheduler instances (defaults, MAX_SCORE=99, SETTLE_CYCLES=3).
module tb_score_bcd_scheduler;

   logic              clock;
   logic [2:0]        reset, req_a, req_b, ack_a, ack_b, sat_a, sat_b, busy;
   logic [2:0][7:0]   score_a, score_b;
   logic [2:0][11:0]  bcd_a, bcd_b;
   int                n_checks;
   int                n_fail;

   score_bcd_scheduler u_dflt (
      .clock(clock), .reset(reset[0]), .req_a(req_a[0]), .req_b(req_b[0]),
      .score_a(score_a[0]), .score_b(score_b[0]), .ack_a(ack_a[0]), .ack_b(ack_b[0]),
      .bcd_a(bcd_a[0]), .bcd_b(bcd_b[0]), .sat_a(sat_a[0]), .sat_b(sat_b[0]), .busy(busy[0])
   );

   score_bcd_scheduler #(.MAX_SCORE(99)) u_sat (
      .clock(clock), .reset(reset[1]), .req_a(req_a[1]), .req_b(req_b[1]),
      .score_a(score_a[1]), .score_b(score_b[1]), .ack_a(ack_a[1]), .ack_b(ack_b[1]),
      .bcd_a(bcd_a[1]), .bcd_b(bcd_b[1]), .sat_a(sat_a[1]), .sat_b(sat_b[1]), .busy(busy[1])
   );

   score_bcd_scheduler #(.SETTLE_CYCLES(3)) u_slow (
      .clock(clock), .reset(reset[2]), .req_a(req_a[2]), .req_b(req_b[2]),
      .score_a(score_a[2]), .score_b(score_b[2]), .ack_a(ack_a[2]), .ack_b(ack_b[2]),
      .bcd_a(bcd_a[2]), .bcd_b(bcd_b[2]), .sat_a(sat_a[2]), .sat_b(sat_b[2]), .busy(busy[2])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [11:0] dec_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one request, releases it after the granting edge, and returns the
   // number of edges (granting edge included) until ack is seen, or -1.
   task automatic run_conv(input int k, input bit side_b, input logic [7:0] score, output int lat);
      if (side_b) begin
         req_b[k] = 1'b1;
         score_b[k] = score;
      end else begin
         req_a[k] = 1'b1;
         score_a[k] = score;
      end
      tick();
      lat = 1;
      req_a[k] = 1'b0;
      req_b[k] = 1'b0;
      while (!(side_b ? ack_b[k] : ack_a[k]) && lat < 40) begin
         tick();
         lat++;
      end
      if (!(side_b ? ack_b[k] : ack_a[k])) lat = -1;
      tick();
   endtask

   task automatic test_reset();
      reset = 3'b111;
      req_a = '0;
      req_b = '0;
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (busy[k] !== 1'b0 || ack_a[k] !== 1'b0 || ack_b[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl[%0d]: busy=%b ack_a=%b ack_b=%b, required all 0", k, busy[k], ack_a[k], ack_b[k]);
         end
         n_checks++;
         if (bcd_a[k] !== 12'h000 || bcd_b[k] !== 12'h000 || sat_a[k] !== 1'b0 || sat_b[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data[%0d]: bcd_a=%h bcd_b=%h sat_a=%b sat_b=%b, required 000 000 0 0",
                     k, bcd_a[k], bcd_b[k], sat_a[k], sat_b[k]);
         end
      end
      reset = 3'b000;
      tick();
   endtask

   task automatic test_single();
      req_a[0] = 1'b1;
      score_a[0] = 8'd57;
      tick();
      n_checks++;
      if (busy[0] !== 1'b1 || ack_a[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_grant: busy=%b ack_a=%b, required 1 0", busy[0], ack_a[0]);
      end
      req_a[0] = 1'b0;
      tick();
      n_checks++;
      if (ack_a[0] !== 1'b1 || ack_b[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: ack_a=%b ack_b=%b, required 1 0", ack_a[0], ack_b[0]);
      end
      n_checks++;
      if (bcd_a[0] !== 12'h057 || sat_a[0] !== 1'b0 || bcd_b[0] !== 12'h000) begin
         n_fail++;
         $display("FAIL single_data: bcd_a=%h sat_a=%b bcd_b=%h, required 057 0 000", bcd_a[0], sat_a[0], bcd_b[0]);
      end
      tick();
      n_checks++;
      if (ack_a[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: ack_a=%b busy=%b, required 0 0", ack_a[0], busy[0]);
      end
   endtask

   task automatic test_tie();
      int ta;
      int tb;
      ta = -1;
      tb = -1;
      reset[0] = 1'b1;
      tick();
      reset[0] = 1'b0;
      req_a[0] = 1'b1;
      req_b[0] = 1'b1;
      score_a[0] = 8'd200;
      score_b[0] = 8'd9;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (ack_a[0] && ta < 0) begin
            ta = c;
            req_a[0] = 1'b0;
            n_checks++;
            if (bcd_a[0] !== 12'h200 || bcd_b[0] !== 12'h000) begin
               n_fail++;
               $display("FAIL tie_a_data: bcd_a=%h bcd_b=%h, required 200 000", bcd_a[0], bcd_b[0]);
            end
         end
         if (ack_b[0] && tb < 0) begin
            tb = c;
            req_b[0] = 1'b0;
            n_checks++;
            if (bcd_b[0] !== 12'h009 || bcd_a[0] !== 12'h200) begin
               n_fail++;
               $display("FAIL tie_b_data: bcd_b=%h bcd_a=%h, required 009 200", bcd_b[0], bcd_a[0]);
            end
         end
      end
      n_checks++;
      if (ta != 1 || tb != 4) begin
         n_fail++;
         $display("FAIL tie_timing: ack_a at %0d ack_b at %0d, required 1 and 4 (3 apart, A first)", ta, tb);
      end
   endtask

   task automatic test_alternate();
      int nacks;
      int overlap;
      bit seq [6];
      nacks = 0;
      overlap = 0;
      req_a[0] = 1'b1;
      req_b[0] = 1'b1;
      for (int c = 0; c < 60 && nacks < 6; c++) begin
         tick();
         if (ack_a[0] && ack_b[0]) overlap++;
         if (ack_a[0]) begin
            seq[nacks] = 1'b0;
            nacks++;
         end else if (ack_b[0]) begin
            seq[nacks] = 1'b1;
            nacks++;
         end
      end
      req_a[0] = 1'b0;
      req_b[0] = 1'b0;
      tick();
      tick();
      n_checks++;
      if (nacks != 6 || overlap != 0) begin
         n_fail++;
         $display("FAIL alt_count: acks=%0d overlaps=%0d, required 6 0", nacks, overlap);
      end
      for (int i = 0; i < nacks; i++) begin
         n_checks++;
         if (seq[i] !== 1'(i % 2)) begin
            n_fail++;
            $display("FAIL alt_order[%0d]: owner=%0d, required %0d (0=A 1=B)", i, seq[i], i % 2);
         end
      end
   endtask

   task automatic test_saturate();
      int lat;
      logic [7:0] scores [4];
      logic [11:0] exp_bcd [4];
      logic exp_sat [4];
      scores  = '{8'd150, 8'd42, 8'd99, 8'd100};
      exp_bcd = '{12'h099, 12'h042, 12'h099, 12'h099};
      exp_sat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_conv(1, 1'b1, scores[i], lat);
         n_checks++;
         if (lat != 2 || bcd_b[1] !== exp_bcd[i] || sat_b[1] !== exp_sat[i]) begin
            n_fail++;
            $display("FAIL sat_b[%0d]: lat=%0d bcd_b=%h sat_b=%b, required 2 %h %b",
                     scores[i], lat, bcd_b[1], sat_b[1], exp_bcd[i], exp_sat[i]);
         end
      end
      n_checks++;
      if (bcd_a[1] !== 12'h000 || sat_a[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_other: bcd_a=%h sat_a=%b, required 000 0", bcd_a[1], sat_a[1]);
      end
   endtask

   task automatic test_reset_abort();
      bit saw_ack;
      saw_ack = 1'b0;
      req_a[2] = 1'b1;
      score_a[2] = 8'd255;
      tick();
      req_a[2] = 1'b0;
      n_checks++;
      if (busy[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_busy: busy=%b, required 1", busy[2]);
      end
      tick();
      #2 reset[2] = 1'b1;
      #2;
      n_checks++;
      if (busy[2] !== 1'b0 || ack_a[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: busy=%b ack_a=%b, required 0 0", busy[2], ack_a[2]);
      end
      #1 reset[2] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ack_a[2]) saw_ack = 1'b1;
      end
      n_checks++;
      if (saw_ack || bcd_a[2] !== 12'h000 || sat_a[2] !== 1'b0 || busy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_after: ack_seen=%b bcd_a=%h sat_a=%b busy=%b, required 0 000 0 0",
                  saw_ack, bcd_a[2], sat_a[2], busy[2]);
      end
   endtask

   task automatic test_sweep();
      int lat;
      for (int v = 0; v < 256; v++) begin
         run_conv(2, 1'b0, 8'(v), lat);
         n_checks++;
         if (bcd_a[2] !== dec_bcd(v) || lat != 4) begin
            n_fail++;
            $display("FAIL sweep[%0d]: bcd_a=%h lat=%0d, required %h 4", v, bcd_a[2], lat, dec_bcd(v));
         end
      end
      n_checks++;
      if (sat_a[2] !== 1'b0 || bcd_b[2] !== 12'h000) begin
         n_fail++;
         $display("FAIL sweep_other: sat_a=%b bcd_b=%h, required 0 000", sat_a[2], bcd_b[2]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail = 0;
      reset = 3'b111;
      req_a = '0;
      req_b = '0;
      score_a = '0;
      score_b = '0;
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_saturate();
      test_reset_abort();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
